// File: rtl/page_walker.sv
// page_walker: two-level (10/10/12) hardware page-table walker servicing TLB misses.
//
// A TLB miss (fault) latches the faulting virtual address and the page-table base,
// then reads the level-1 and level-0 PTEs through a req/gnt/rvalid read port. A
// successful walk returns the physical address on fault_input with a one-cycle
// unfault strobe, followed by one HOLD cycle that ignores the TLB's stale fault.
// A failed walk raises page_fault (fault_input = va) until pf_ack.
//
// PTE format: bit0 V, bit1 L (leaf), [31:12] PPN.
//
// Optional feature: define PAGE_WALKER_SUPERPAGE_EN to accept a level-1 leaf as a
// superpage. Without it a level-1 leaf is reported as a page fault.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   fault             TLB miss request (level)
//   compare_input     faulting virtual address
//   ptbr              page table base, bits [31:12] used
//   fault_input       translated physical address (or va on page fault)
//   unfault           one-cycle refill strobe
//   mem_req/mem_addr  registered read request, held until mem_gnt
//   mem_gnt           request accepted this cycle
//   mem_rvalid/rdata  read data return
//   page_fault        failed translation, held until pf_ack
//   pf_ack            page fault acknowledge
//   busy              walker not idle
module page_walker #(
    parameter int unsigned BIT_COUNT = 32,
    parameter int unsigned PAGE_BITS = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fault,
    input  logic [BIT_COUNT-1:0] compare_input,
    input  logic [BIT_COUNT-1:0] ptbr,
    output logic [BIT_COUNT-1:0] fault_input,
    output logic                 unfault,
    output logic                 mem_req,
    output logic [BIT_COUNT-1:0] mem_addr,
    input  logic                 mem_gnt,
    input  logic                 mem_rvalid,
    input  logic [BIT_COUNT-1:0] mem_rdata,
    output logic                 page_fault,
    input  logic                 pf_ack,
    output logic                 busy
);

    localparam int unsigned PpnW = BIT_COUNT - PAGE_BITS;
    localparam int unsigned VpnW = PpnW / 2;

    typedef enum logic [2:0] {
        StIdle,
        StL1Req,
        StL1Wait,
        StL0Req,
        StL0Wait,
        StHold,
        StPf
    } state_e;

    state_e                state_q, state_d;
    logic [BIT_COUNT-1:0]  va_q, va_d;
    logic [PpnW-1:0]       base_q, base_d;
    logic [BIT_COUNT-1:0]  fault_input_q, fault_input_d;
    logic                  unfault_q, unfault_d;
    logic                  mem_req_q, mem_req_d;
    logic [BIT_COUNT-1:0]  mem_addr_q, mem_addr_d;
    logic                  page_fault_q, page_fault_d;

    logic                  pte_v;
    logic                  pte_l;
    logic [PpnW-1:0]       pte_ppn;

    assign pte_v   = mem_rdata[0];
    assign pte_l   = mem_rdata[1];
    assign pte_ppn = mem_rdata[BIT_COUNT-1:PAGE_BITS];

    // PTE flag-gap bits and the ptbr offset are architecturally ignored.
    logic unused_ok;
    assign unused_ok = ^{ptbr[PAGE_BITS-1:0], mem_rdata[PAGE_BITS-1:2]};

    always_comb begin
        state_d       = state_q;
        va_d          = va_q;
        base_d        = base_q;
        fault_input_d = fault_input_q;
        unfault_d     = 1'b0;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        page_fault_d  = page_fault_q;

        case (state_q)
            StIdle: begin
                if (fault) begin
                    va_d    = compare_input;
                    base_d  = ptbr[BIT_COUNT-1:PAGE_BITS];
                    state_d = StL1Req;
                end
            end

            StL1Req: begin
                // First cycle here launches the request from the latched va/base;
                // a grant only counts once the request is actually visible.
                if (!mem_req_q) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = {base_q, va_q[BIT_COUNT-1 -: VpnW], 2'b00};
                end else if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    state_d   = StL1Wait;
                end
            end

            StL1Wait: begin
                if (mem_rvalid) begin
                    if (!pte_v) begin
                        page_fault_d  = 1'b1;
                        fault_input_d = va_q;
                        state_d       = StPf;
                    end else if (!pte_l) begin
                        // Pointer PTE: next table base, issue the L0 read straight away.
                        base_d     = pte_ppn;
                        mem_req_d  = 1'b1;
                        mem_addr_d = {pte_ppn, va_q[PAGE_BITS +: VpnW], 2'b00};
                        state_d    = StL0Req;
                    end else begin
`ifdef PAGE_WALKER_SUPERPAGE_EN
                        fault_input_d = {mem_rdata[BIT_COUNT-1 -: VpnW],
                                         va_q[BIT_COUNT-VpnW-1:0]};
                        unfault_d     = 1'b1;
                        state_d       = StHold;
`else
                        page_fault_d  = 1'b1;
                        fault_input_d = va_q;
                        state_d       = StPf;
`endif
                    end
                end
            end

            StL0Req: begin
                if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    state_d   = StL0Wait;
                end
            end

            StL0Wait: begin
                if (mem_rvalid) begin
                    if (pte_v && pte_l) begin
                        fault_input_d = {pte_ppn, va_q[PAGE_BITS-1:0]};
                        unfault_d     = 1'b1;
                        state_d       = StHold;
                    end else begin
                        page_fault_d  = 1'b1;
                        fault_input_d = va_q;
                        state_d       = StPf;
                    end
                end
            end

            // The TLB still shows fault for the refilled miss during this cycle.
            StHold: begin
                state_d = StIdle;
            end

            StPf: begin
                if (pf_ack) begin
                    page_fault_d = 1'b0;
                    state_d      = StIdle;
                end
            end

            default: begin
                state_d      = StIdle;
                mem_req_d    = 1'b0;
                page_fault_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            va_q          <= '0;
            base_q        <= '0;
            fault_input_q <= '0;
            unfault_q     <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            page_fault_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            va_q          <= va_d;
            base_q        <= base_d;
            fault_input_q <= fault_input_d;
            unfault_q     <= unfault_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            page_fault_q  <= page_fault_d;
        end
    end

    assign fault_input = fault_input_q;
    assign unfault     = unfault_q;
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign page_fault  = page_fault_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_page_walker.sv
// Self-checking bench for page_walker: directed test-plan walks plus randomized
// page tables checked against a behavioural translation model.
module tb_page_walker;

    logic        clk;
    logic        rst;
    logic        fault;
    logic [31:0] compare_input;
    logic [31:0] ptbr;
    logic [31:0] fault_input;
    logic        unfault;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        page_fault;
    logic        pf_ack;
    logic        busy;

    page_walker #(
        .BIT_COUNT(32),
        .PAGE_BITS(12)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fault        (fault),
        .compare_input(compare_input),
        .ptbr         (ptbr),
        .fault_input  (fault_input),
        .unfault      (unfault),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .page_fault   (page_fault),
        .pf_ack       (pf_ack),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;
    int gnt_dly = 0;
    int rv_dly = 0;
    int gnt_count = 0;
    int unfault_cnt = 0;
    int last_n = 0;
    logic [31:0] req_log[$];
    logic [31:0] pt_mem[logic [31:0]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pt_read(input logic [31:0] a);
        if (pt_mem.exists(a)) return pt_mem[a];
        return 32'h0;
    endfunction

    // Reference translation: returns the number of table reads a walk performs.
    function automatic int model_walk(input logic [31:0] va, input logic [31:0] p,
                                      output logic ok, output logic [31:0] res,
                                      output logic [31:0] a1, output logic [31:0] a0);
        logic [31:0] pte;
        ok  = 1'b0;
        res = va;
        a0  = 32'h0;
        a1  = (p & 32'hFFFF_F000) + (va >> 22) * 32'd4;
        pte = pt_read(a1);
        if (pte[0] == 1'b0) return 1;
        if (pte[1] == 1'b1) begin
`ifdef PAGE_WALKER_SUPERPAGE_EN
            ok  = 1'b1;
            res = (pte & 32'hFFC0_0000) | (va & 32'h003F_FFFF);
`endif
            return 1;
        end
        a0  = (pte & 32'hFFFF_F000) + ((va >> 12) & 32'h3FF) * 32'd4;
        pte = pt_read(a0);
        if (pte[0] && pte[1]) begin
            ok  = 1'b1;
            res = (pte & 32'hFFFF_F000) | (va & 32'h0000_0FFF);
        end
        return 2;
    endfunction

    // Memory responder: grant after gnt_dly cycles, data after a further rv_dly.
    initial begin : responder
        logic [31:0] a;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        @(posedge clk);
        #1;
        forever begin
            if (mem_req !== 1'b1) begin
                mem_rdata = $urandom;
                @(posedge clk);
                #1;
            end else begin
                a = mem_addr;
                req_log.push_back(a);
                for (int i = 0; i < gnt_dly; i++) begin
                    @(posedge clk);
                    #1;
                    check("req_held", 32'(mem_req), 32'h1);
                    check("addr_held", mem_addr, a);
                end
                mem_gnt = 1'b1;
                @(posedge clk);
                #1;
                mem_gnt = 1'b0;
                gnt_count++;
                for (int i = 0; i < rv_dly; i++) begin
                    mem_rdata = $urandom;
                    @(posedge clk);
                    #1;
                end
                mem_rvalid = 1'b1;
                mem_rdata  = pt_read(a);
                @(posedge clk);
                #1;
                mem_rvalid = 1'b0;
            end
        end
    end

    initial begin : unfault_monitor
        forever begin
            @(negedge clk);
            if (unfault === 1'b1) unfault_cnt++;
        end
    end

    task automatic run_walk(input logic [31:0] va, input logic [31:0] p, input int g,
                            input int r, input bit hold_fault, input bit early_ack);
        logic        ok;
        logic [31:0] res;
        logic [31:0] a1;
        logic [31:0] a0;
        int          nacc;
        int          n;
        int          k;
        int          uf0;
        bit          done;
        nacc    = model_walk(va, p, ok, res, a1, a0);
        gnt_dly = g;
        rv_dly  = r;
        req_log.delete();
        uf0 = unfault_cnt;
        compare_input = va;
        ptbr          = p;
        fault         = 1'b1;
        pf_ack        = early_ack;
        n    = 0;
        done = 1'b0;
        while (!done && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1 && !hold_fault) begin
                fault         = 1'b0;
                compare_input = $urandom;
                ptbr          = $urandom;
            end
            if (unfault === 1'b1 || page_fault === 1'b1) done = 1'b1;
        end
        last_n = n;
        check("walk_done", 32'(done), 32'h1);
        check("latency", n, 2 + nacc * (2 + g + r));
        check("unfault", 32'(unfault), 32'(ok));
        check("page_fault", 32'(page_fault), 32'(!ok));
        check("result", fault_input, res);
        check("busy_at_end", 32'(busy), 32'h1);
        check("n_reads", req_log.size(), nacc);
        if (req_log.size() > 0) check("l1_addr", req_log[0], a1);
        if (req_log.size() > 1) check("l0_addr", req_log[1], a0);
        if (ok) begin
            @(posedge clk);
            #1;
            check("unfault_1cyc", 32'(unfault), 32'h0);
            check("hold_exit", 32'(busy), 32'h0);
            check("result_held", fault_input, res);
        end else if (early_ack) begin
            @(posedge clk);
            #1;
            pf_ack = 1'b0;
            check("pf_fast_clear", 32'(page_fault), 32'h0);
            check("pf_fast_idle", 32'(busy), 32'h0);
        end else begin
            k = $urandom_range(1, 3);
            repeat (k) begin
                @(posedge clk);
                #1;
                check("pf_held", 32'(page_fault), 32'h1);
                check("pf_va", fault_input, va);
            end
            pf_ack = 1'b1;
            @(posedge clk);
            #1;
            pf_ack = 1'b0;
            check("pf_clear", 32'(page_fault), 32'h0);
            check("pf_idle", 32'(busy), 32'h0);
        end
        pf_ack = 1'b0;
        check("unfault_count", unfault_cnt - uf0, ok ? 1 : 0);
    endtask

    task automatic plan_table(input logic [31:0] l1_pte);
        pt_mem.delete();
        pt_mem[32'h0001_0FFC] = l1_pte;
        pt_mem[32'h0002_0FFC] = 32'h1000_0003;
    endtask

    initial begin : main
        logic [31:0] va;
        logic [31:0] p;
        logic [31:0] rnd;
        logic [31:0] pte1;
        logic [31:0] pte2;
        logic [31:0] l1a;
        logic [31:0] l0a;
        int          n;
        int          g0;
        int          uf0;
        int          kind;

        rst           = 1'b0;
        fault         = 1'b0;
        compare_input = 32'h0;
        ptbr          = 32'h0;
        pf_ack        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_fault_input", fault_input, 32'h0);
        check("rst_unfault", 32'(unfault), 32'h0);
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_page_fault", 32'(page_fault), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Basic two-level walk, minimum latency.
        plan_table(32'h0002_0001);
        run_walk(32'hFFFF_F00A, 32'h0001_0000, 0, 0, 1'b0, 1'b0);
        check("tp_basic_pa", fault_input, 32'h1000_000A);
        check("tp_basic_lat", last_n, 6);

        // Invalid L1 PTE.
        plan_table(32'h0002_0000);
        run_walk(32'hFFFF_F00A, 32'h0001_0000, 0, 0, 1'b0, 1'b0);
        check("tp_inv_va", fault_input, 32'hFFFF_F00A);

        // Level-1 leaf.
        plan_table(32'h1240_0003);
        run_walk(32'hFFFF_F00A, 32'h0001_0000, 1, 0, 1'b0, 1'b0);
`ifdef PAGE_WALKER_SUPERPAGE_EN
        check("tp_super_pa", fault_input, 32'h127F_F00A);
`else
        check("tp_super_pf_va", fault_input, 32'hFFFF_F00A);
`endif

        // Slow memory: grant late, data later.
        plan_table(32'h0002_0001);
        run_walk(32'hFFFF_F00A, 32'h0001_0000, 3, 4, 1'b0, 1'b0);
        check("tp_slow_pa", fault_input, 32'h1000_000A);
        check("tp_slow_lat", last_n, 20);

        // Acknowledge already high when page_fault rises.
        plan_table(32'h0002_0001);
        pt_mem[32'h0002_0FFC] = 32'h1000_0001;
        run_walk(32'hFFFF_F00A, 32'h0001_0000, 0, 1, 1'b0, 1'b1);

        // Reset while the L0 read is outstanding.
        plan_table(32'h0002_0001);
        gnt_dly = 0;
        rv_dly  = 4;
        g0      = gnt_count;
        uf0     = unfault_cnt;
        compare_input = 32'hFFFF_F00A;
        ptbr          = 32'h0001_0000;
        fault         = 1'b1;
        @(posedge clk);
        #1;
        fault = 1'b0;
        n = 0;
        while (gnt_count < g0 + 2 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("rst_reach_l0wait", 32'(gnt_count >= g0 + 2), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_fault_input", fault_input, 32'h0);
        check("midrst_unfault", 32'(unfault), 32'h0);
        check("midrst_mem_req", 32'(mem_req), 32'h0);
        check("midrst_mem_addr", mem_addr, 32'h0);
        check("midrst_page_fault", 32'(page_fault), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("postrst_busy", 32'(busy), 32'h0);
        check("postrst_mem_req", 32'(mem_req), 32'h0);
        check("postrst_fault_input", fault_input, 32'h0);
        check("postrst_no_unfault", unfault_cnt - uf0, 0);

        // fault held high across unfault and HOLD: one re-walk, started after HOLD.
        plan_table(32'h0002_0001);
        run_walk(32'hFFFF_F00A, 32'h0001_0000, 0, 0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check("rewalk_start", 32'(busy), 32'h1);
        fault = 1'b0;
        req_log.delete();
        uf0 = unfault_cnt;
        n   = 0;
        while (unfault !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("rewalk_lat", n, 5);
        check("rewalk_pa", fault_input, 32'h1000_000A);
        check("rewalk_reads", req_log.size(), 2);
        @(posedge clk);
        #1;
        check("rewalk_idle", 32'(busy), 32'h0);
        check("rewalk_one_unfault", unfault_cnt - uf0, 1);

        // Randomized page tables.
        for (int it = 0; it < 24; it++) begin
            va = $urandom;
            p  = $urandom;
            pt_mem.delete();
            l1a  = (p & 32'hFFFF_F000) + (va >> 22) * 32'd4;
            rnd  = $urandom;
            kind = $urandom_range(0, 3);
            pte1 = (rnd & 32'hFFFF_FFFC) | (kind == 0 ? 32'h0 : (kind == 1 ? 32'h3 : 32'h1));
            if ($urandom_range(0, 7) != 0) pt_mem[l1a] = pte1;
            if (kind >= 2) begin
                l0a  = (pte1 & 32'hFFFF_F000) + ((va >> 12) & 32'h3FF) * 32'd4;
                rnd  = $urandom;
                kind = $urandom_range(0, 3);
                pte2 = (rnd & 32'hFFFF_FFFC) |
                       (kind == 0 ? 32'h0 : (kind == 1 ? 32'h1 : 32'h3));
                pt_mem[l0a] = pte2;
            end
            run_walk(va, p, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0,
                     ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/page_walker.md
# page_walker

Hardware page-table walker that services TLB misses. It sits between the TLB and the memory read port. When the TLB raises `fault` for a virtual address, the walker performs a two-level table walk from `ptbr`, then returns the translated physical address on `fault_input` with a one-cycle `unfault` pulse (the TLB refill handshake). Invalid or malformed translations are reported on `page_fault` and held until software acknowledges them.

## Interface
- `BIT_COUNT`, 32, address/data width (fixed two-level 10/10/12 split requires 32)
- `PAGE_BITS`, 12, page offset width; equals $clog2(page_size)

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `fault`  in  1  TLB miss indication (level)
- `compare_input`  in  32  faulting virtual address from TLB
- `ptbr`  in  32  page table base; bits [31:12] used
- `fault_input`  out  32  translated physical address to TLB
- `unfault`  out  1  one-cycle refill strobe to TLB
- `mem_req`  out  1  read request
- `mem_addr`  out  32  PTE address, word aligned
- `mem_gnt`  in  1  request accepted this cycle
- `mem_rvalid`  in  1  read data valid
- `mem_rdata`  in  32  PTE data
- `page_fault`  out  1  translation failed, level until `pf_ack`
- `pf_ack`  in  1  page fault acknowledge
- `busy`  out  1  high in every state except IDLE

## Operation
- PTE format: bit0 V (valid), bit1 L (leaf), [31:12] PPN; other bits ignored.
- States: IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, HOLD, PF.
- IDLE: on `fault`=1, latch `compare_input` -> va, `ptbr`[31:12] -> base; go L1_REQ. Later changes to inputs are ignored.
- L1_REQ: `mem_req`=1, `mem_addr`={base, va[31:22], 2'b00}; on `mem_gnt` go L1_WAIT.
- L1_WAIT: on `mem_rvalid`:
  - V=0 -> PF
  - V=1, L=0 -> base=PPN, go L0_REQ
  - V=1, L=1 -> superpage (see Configuration)
- L0_REQ: `mem_addr`={base, va[21:12], 2'b00}; on `mem_gnt` go L0_WAIT.
- L0_WAIT: on `mem_rvalid`:
  - V=1, L=1 -> `fault_input`={PPN, va[11:0]}, `unfault`=1 for one cycle, go HOLD
  - otherwise -> PF
- HOLD: one cycle with `fault` ignored, covering the TLB's stale `fault` register; then IDLE.
- PF: `page_fault`=1, `fault_input` holds va. On `pf_ack` go IDLE. `unfault` is never asserted for a failed walk.
- `mem_rvalid` outside a WAIT state is ignored. `mem_req` never overlaps an outstanding read.

## Timing
- Reset (async assert, sync use on deassert): state IDLE; `fault_input`=0, `unfault`=0, `mem_req`=0, `mem_addr`=0, `page_fault`=0, `busy`=0. Reset mid-walk abandons the walk; data returned later is ignored.
- `mem_req`/`mem_addr` are registered and held stable until the cycle `mem_gnt`=1.
- Minimum latency, with `mem_gnt` and `mem_rvalid` each arriving one cycle after request or grant: `fault` high at edge 0 -> `unfault` high after edge 5.
- `fault_input` is valid in the same cycle as `unfault` and holds until the next walk starts.
- `pf_ack` in the same cycle `page_fault` rises is honoured: exit after one cycle.
- `fault`=1 in the cycle after HOLD starts a new walk.

## Configuration
- `PAGE_WALKER_SUPERPAGE_EN` defined: a level-1 leaf is legal.
  - `fault_input`={PPN[31:22], va[21:0]}
  - `unfault` pulses, go HOLD (no L0 access)
- Not defined: a level-1 leaf -> PF.

## Test plan
- ptbr=0x00010000, va=0xFFFFF00A. L1 read at 0x00010FFC returns 0x00020001; L0 read at 0x00020FFC returns 0x10000003 -> `fault_input`=0x1000000A, `unfault` pulse, 5-cycle latency.
- Same setup, L1 PTE 0x00020000 (V=0) -> no L0 request, `page_fault`=1 until `pf_ack`, `unfault` never high.
- L1 PTE 0x12400003:
  - with `PAGE_WALKER_SUPERPAGE_EN` -> `fault_input`=0x127FF00A
  - without the macro -> PF
- `mem_gnt` delayed 3 cycles, `mem_rvalid` delayed 4 -> `mem_addr` stable throughout, result identical.
- `rst` low during L0_WAIT, then `mem_rvalid` arrives -> IDLE, all outputs 0, no `unfault`.
- `fault` held high across `unfault` and HOLD -> exactly one walk per HOLD exit, second walk starts the cycle after HOLD.
